// File: rtl/multicycle_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm_pkg
//  Purpose  : Shared encodings for the multi-cycle MIPS control sequencer:
//             state codes, opcode/funct constants, ALUop, pc_source, ALU
//             operand select and write-back select encodings, plus the
//             bundled control-word type driven onto the datapath.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_fsm_pkg;

    // Sequencer state codes; the numeric values are visible on the debug port
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9,
        S_IEXE   = 4'd10,
        S_IWB    = 4'd11,
        S_JR     = 4'd12,
        S_JAL    = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    // Instruction opcodes (IR[31:26]) and the one funct code the sequencer needs
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // ALUop handed to ALU_control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OPC   = 2'b11;

    // PC source mux
    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RS     = 2'd3;

    // ALU operand A / B muxes
    localparam logic       SRCA_PC   = 1'b0;
    localparam logic       SRCA_RS   = 1'b1;
    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BOFF = 2'd3;

    // Register-file write address / data muxes
    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;
    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    // Complete control word presented to the datapath in one cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
    } ctrl_t;

    // States that stall on the memory-ready handshake
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MRD) || (s == S_MWR);
    endfunction

endpackage : multicycle_ctrl_fsm_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_wait_timer
//  Purpose  : Memory wait-state counter for the control sequencer. Counts
//             cycles spent stalled on mem_ready and flags the last permitted
//             stall cycle so the sequencer can trap instead of waiting again.
//  Ports    : clk      - rising-edge clock
//             rst_n    - asynchronous active-low reset
//             clear    - return count to zero (wins over count_en)
//             count_en - one more stalled cycle observed
//             expire   - current stall cycle is the LIMIT-th one
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_wait_timer #(
    parameter int unsigned LIMIT = 15,
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    // Saturates at C_LAST; the sequencer leaves the wait state before any wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != C_LAST)) begin
            count <= count + 1'b1;
        end
    end

    // Count already holds LIMIT-1 earlier stall cycles, so a stall now is the LIMIT-th
    assign expire = (count == C_LAST);

endmodule : ctrl_wait_timer
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Purpose  : Control sequencer for the multi-cycle MIPS datapath. Steps each
//             instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath
//             enables, mux selects and ALUop, waits on mem_ready and traps on
//             memory timeout or an illegal opcode.
//  Ports    : clk, rst_n (async active-low)
//             run            - permits a new FETCH
//             opcode, funct  - IR fields, sampled in DECODE
//             mem_ready      - memory completes the access this cycle
//             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//             reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
//             pc_source      - datapath control
//             retire         - pulse on final cycle of each instruction
//             trap           - sticky illegal-opcode / timeout flag
//             state          - current state code (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMO_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state
);

    state_t cur_state;
    state_t nxt_state;
    logic   is_store;
    logic   trap_q;
    logic   waiting;
    logic   wait_clear;
    logic   expire;
    logic   timeout;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;

    // ------------------------------------------------------------------
    // Stall detection. An idle FETCH (run=0) is not a stall, so the timer
    // is held at zero there; leaving or entering a memory state clears it.
    // ------------------------------------------------------------------
    always_comb begin
        waiting = 1'b0;
        if (is_mem_state(cur_state)) begin
            if (cur_state == S_FETCH) begin
                waiting = run & ~mem_ready;
            end else begin
                waiting = ~mem_ready;
            end
        end
    end

    assign wait_clear = ~waiting;

    ctrl_wait_timer #(
        .LIMIT (MEM_TIMEOUT),
        .WIDTH (TMO_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wait_clear),
        .count_en (waiting),
        .expire   (expire)
    );

    // mem_ready in the expiring cycle suppresses waiting, so completion wins
    assign timeout = waiting & expire;

    // ------------------------------------------------------------------
    // State register, load/store flag and sticky trap
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            is_store  <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            // opcode is only guaranteed valid in DECODE; MADDR needs lw/sw
            if (cur_state == S_DECODE) begin
                is_store <= (opcode == OP_SW);
            end
            if (nxt_state == S_TRAP) begin
                trap_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                if (run && mem_ready) begin
                    nxt_state = S_DECODE;
                end else if (timeout) begin
                    nxt_state = S_TRAP;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MADDR;
                    OP_RTYPE:     nxt_state = (funct == FN_JR) ? S_JR : S_REXE;
                    OP_BEQ:       nxt_state = S_BEQ;
                    OP_J:         nxt_state = S_JMP;
                    OP_JAL:       nxt_state = S_JAL;
                    OP_ADDI:      nxt_state = S_IEXE;
                    default:      nxt_state = S_TRAP;
                endcase
            end
            S_MADDR: nxt_state = is_store ? S_MWR : S_MRD;
            S_MRD: begin
                if (mem_ready) begin
                    nxt_state = S_MWB;
                end else if (timeout) begin
                    nxt_state = S_TRAP;
                end
            end
            S_MWR: begin
                if (mem_ready) begin
                    nxt_state = S_FETCH;
                end else if (timeout) begin
                    nxt_state = S_TRAP;
                end
            end
            S_REXE:  nxt_state = S_RWB;
            S_IEXE:  nxt_state = S_IWB;
            S_MWB, S_RWB, S_IWB, S_BEQ, S_JMP, S_JR, S_JAL: nxt_state = S_FETCH;
            S_TRAP:  nxt_state = S_TRAP;
            default: nxt_state = S_TRAP;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: Moore on state, with memory-state strobes qualified
    // by run / mem_ready so that loads happen only on the completing cycle.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl = '0;
        case (cur_state)
            S_FETCH: begin
                if (run) begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.iord      = 1'b0;
                    ctrl.alu_src_a = SRCA_PC;
                    ctrl.alu_src_b = SRCB_ONE;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCS_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_BOFF;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MADDR, S_IEXE: begin
                ctrl.alu_src_a = SRCA_RS;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RDST_RT;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.retire     = 1'b1;
            end
            S_MWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.retire    = mem_ready;
            end
            S_REXE: begin
                ctrl.alu_src_a = SRCA_RS;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RDST_RD;
                ctrl.mem_to_reg = M2R_ALU;
                ctrl.retire     = 1'b1;
            end
            S_IWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RDST_RT;
                ctrl.mem_to_reg = M2R_ALU;
                ctrl.retire     = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = SRCA_RS;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            S_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
                ctrl.retire    = 1'b1;
            end
            S_JR: begin
                ctrl.alu_src_a = SRCA_RS;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_RS;
                ctrl.retire    = 1'b1;
            end
            S_JAL: begin
                // Link value is the PC already incremented during FETCH
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RDST_RA;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCS_JUMP;
                ctrl.retire     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Reset forces the control word quiet immediately, so no partial write
    // can complete while rst_n is low, independent of run / mem_ready.
    assign ctrl_out = rst_n ? ctrl : '0;

    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign iord          = ctrl_out.iord;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign reg_write     = ctrl_out.reg_write;
    assign reg_dst       = ctrl_out.reg_dst;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign pc_source     = ctrl_out.pc_source;
    assign retire        = ctrl_out.retire;
    assign trap          = trap_q;
    assign state         = cur_state;

endmodule : multicycle_ctrl_fsm
`default_nettype wire
